final_project_score_keeper: RTL

Game-score datapath and round controller sitting directly upstream of the three-digit seven-segment score display. It turns game hit/miss events into a saturating 7-bit score with a streak bonus, runs the round timer and life counter, and tracks the session high score. Its `score` output drives the display's 7-bit score input directly. `high_score` can be routed to a second display instance.

---
 rtl/final_project_score_keeper_pkg.sv | 25 ++
 rtl/final_project_score_keeper_edge_detect.sv | 17 +
 rtl/final_project_score_keeper.sv | 105 ++++++++++
 3 files changed

// File: rtl/final_project_score_keeper_pkg.sv
// Shared constants for the score keeper: FSM encodings, streak thresholds,
// point values and the score ceiling.
package final_project_score_keeper_pkg;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_PLAYING   = 2'd1;
    localparam logic [1:0] ST_GAME_OVER = 2'd2;

    localparam logic [3:0] STREAK_T1  = 4'd4;
    localparam logic [3:0] STREAK_T2  = 4'd8;
    localparam logic [3:0] STREAK_MAX = 4'd15;

    localparam logic [7:0] PTS_LO    = 8'd1;
    localparam logic [7:0] PTS_MID   = 8'd2;
    localparam logic [7:0] PTS_HI    = 8'd3;
    localparam logic [7:0] SCORE_MAX = 8'd127;

    // Points awarded for a hit, chosen by the streak before it increments.
    function automatic logic [7:0] hit_points(input logic [3:0] streak);
        if (streak >= STREAK_T2)      return PTS_HI;
        else if (streak >= STREAK_T1) return PTS_MID;
        else                          return PTS_LO;
    endfunction

endpackage

// File: rtl/final_project_score_keeper_edge_detect.sv
// Rising-edge detector; the history flop resets high so a level held through
// reset does not register as an event.
module final_project_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic rise
);
    logic prev;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) prev <= 1'b1;
        else      prev <= in;
    end

    assign rise = in & ~prev;
endmodule

// File: rtl/final_project_score_keeper.sv
// Score datapath and round controller: streak-weighted saturating score,
// round timer, lives, and session high score.
module final_project_score_keeper
    import final_project_score_keeper_pkg::*;
#(
    parameter int TICKS_PER_SEC = 50_000_000,
    parameter int ROUND_SECONDS = 30,
    parameter int START_LIVES   = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       hit,
    input  logic       miss,
    output logic [6:0] score,
    output logic [6:0] high_score,
    output logic [5:0] time_left,
    output logic [1:0] lives,
    output logic       playing,
    output logic       game_over
);
    localparam int             PW       = $clog2(TICKS_PER_SEC);
    localparam logic [PW-1:0]  PRE_LAST = PW'(TICKS_PER_SEC - 1);

    logic          start_ev, hit_ev, miss_ev;
    logic [1:0]    state, state_n;
    logic [3:0]    streak, streak_n;
    logic [PW-1:0] presc, presc_n;
    logic [6:0]    score_n;
    logic [5:0]    tl_n;
    logic [1:0]    lives_n;
    logic [7:0]    sum;
    logic          go_first;

    final_project_edge_detect u_start (.clk(clk), .rst(rst), .in(start), .rise(start_ev));
    final_project_edge_detect u_hit   (.clk(clk), .rst(rst), .in(hit),   .rise(hit_ev));
    final_project_edge_detect u_miss  (.clk(clk), .rst(rst), .in(miss),  .rise(miss_ev));

    assign sum = {1'b0, score} + hit_points(streak);

    always_comb begin
        state_n  = state;
        score_n  = score;
        streak_n = streak;
        lives_n  = lives;
        tl_n     = time_left;
        presc_n  = presc;
        case (state)
            ST_PLAYING: begin
                // A miss on the same edge as a hit swallows the hit.
                if (miss_ev) begin
                    streak_n = 4'd0;
                    lives_n  = lives - 2'd1;
                end else if (hit_ev) begin
                    streak_n = (streak == STREAK_MAX) ? streak : streak + 4'd1;
                    score_n  = (sum > SCORE_MAX) ? SCORE_MAX[6:0] : sum[6:0];
                end
                if (presc == PRE_LAST) begin
                    presc_n = '0;
                    tl_n    = time_left - 6'd1;
                end else begin
                    presc_n = presc + 1'b1;
                end
                if (lives_n == 2'd0 || tl_n == 6'd0) state_n = ST_GAME_OVER;
            end
            default: begin
                if (start_ev) begin
                    state_n  = ST_PLAYING;
                    score_n  = 7'd0;
                    streak_n = 4'd0;
                    lives_n  = 2'(START_LIVES);
                    tl_n     = 6'(ROUND_SECONDS);
                    presc_n  = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            score      <= 7'd0;
            streak     <= 4'd0;
            lives      <= 2'(START_LIVES);
            time_left  <= 6'(ROUND_SECONDS);
            presc      <= '0;
            high_score <= 7'd0;
            go_first   <= 1'b0;
            playing    <= 1'b0;
            game_over  <= 1'b0;
        end else begin
            state     <= state_n;
            score     <= score_n;
            streak    <= streak_n;
            lives     <= lives_n;
            time_left <= tl_n;
            presc     <= presc_n;
            go_first  <= (state_n == ST_GAME_OVER) && (state != ST_GAME_OVER);
            playing   <= (state_n == ST_PLAYING);
            game_over <= (state_n == ST_GAME_OVER);
            // Score is frozen in GAME_OVER, so the first cycle there sees the final value.
            if (go_first && score > high_score) high_score <= score;
        end
    end
endmodule
